// File: rtl/rf_port_arbiter.sv
// rtl/rf_port_arbiter.sv - register-file port arbiter with reset-time clear and debug access
module rf_port_arbiter #(
    parameter bit INIT_CLEAR   = 1'b1,
    parameter int STARVE_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        io_cpu_we,
    input  logic [4:0]  io_cpu_wtaddr,
    input  logic [31:0] io_cpu_wtdata,
    input  logic        io_cpu_rdb_use,
    input  logic [4:0]  io_cpu_addrb,
    output logic        io_cpu_stall,
    output logic        io_busy,
    input  logic        io_dbg_req,
    input  logic        io_dbg_wr,
    input  logic [4:0]  io_dbg_addr,
    input  logic [31:0] io_dbg_wdata,
    output logic        io_dbg_ack,
    output logic [31:0] io_dbg_rdata,
    output logic [4:0]  io_rf_addrb,
    input  logic [31:0] io_rf_doutb,
    output logic [4:0]  io_rf_wtaddr,
    output logic [31:0] io_rf_wtdata,
    output logic        io_rf_we
);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_ACK} state_t;

    localparam state_t     RESET_STATE = INIT_CLEAR ? S_INIT : S_RUN;
    localparam logic [7:0] LIMIT       = 8'(STARVE_LIMIT);

    state_t      state, state_next;
    logic [4:0]  ptr, ptr_next;
    logic [7:0]  starve, starve_next;
    logic        grant;
    logic        conflict;
    logic        rf_we_c;

    // A debug write contends for the write port, a debug read for read port B.
    assign conflict = io_dbg_wr ? io_cpu_we : io_cpu_rdb_use;

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        starve_next  = io_dbg_req ? starve : 8'd0;
        grant        = 1'b0;
        io_busy      = 1'b0;
        io_cpu_stall = 1'b0;
        rf_we_c      = io_cpu_we;
        io_rf_wtaddr = io_cpu_wtaddr;
        io_rf_wtdata = io_cpu_wtdata;
        io_rf_addrb  = io_cpu_addrb;
        case (state)
            S_INIT: begin
                io_busy      = 1'b1;
                io_cpu_stall = 1'b1;
                rf_we_c      = 1'b1;
                io_rf_wtaddr = ptr;
                io_rf_wtdata = 32'd0;
                if (ptr == 5'd31) begin
                    state_next = S_RUN;
                end else begin
                    ptr_next = ptr + 5'd1;
                end
            end
            S_RUN: begin
                if (io_dbg_req) begin
                    if (!conflict || starve == LIMIT) begin
                        grant        = 1'b1;
                        state_next   = S_ACK;
                        starve_next  = 8'd0;
                        // Only a forced grant has a conflict; the CPU retries its cycle.
                        io_cpu_stall = conflict;
                        if (io_dbg_wr) begin
                            rf_we_c      = 1'b1;
                            io_rf_wtaddr = io_dbg_addr;
                            io_rf_wtdata = io_dbg_wdata;
                        end else begin
                            io_rf_addrb = io_dbg_addr;
                        end
                    end else if (starve != 8'hFF) begin
                        starve_next = starve + 8'd1;
                    end
                end
            end
            S_ACK: begin
                state_next = S_RUN;
            end
            default: begin
                state_next = RESET_STATE;
            end
        endcase
    end

    assign io_rf_we = rf_we_c & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= RESET_STATE;
            ptr          <= 5'd1;
            starve       <= 8'd0;
            io_dbg_ack   <= 1'b0;
            io_dbg_rdata <= 32'd0;
        end else begin
            state      <= state_next;
            ptr        <= ptr_next;
            starve     <= starve_next;
            io_dbg_ack <= grant;
            if (grant && !io_dbg_wr) begin
                io_dbg_rdata <= (io_dbg_addr == 5'd0) ? 32'd0 : io_rf_doutb;
            end
        end
    end

endmodule
